// File: rtl/nn_layer_seq.sv
// Sequential fully-connected layer: one multiply-accumulate per enabled cycle.
// Results go through optional ReLU and saturation to OW bits.
module nn_layer_seq #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2,
  parameter int XW    = 4,
  parameter int WW    = 8,
  parameter int OW    = 10,
  localparam int WAW  = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  start_i,
  input  logic [N_IN*XW-1:0]    x_i,
  input  logic                  relu_en_i,
  input  logic                  w_we_i,
  input  logic [WAW-1:0]        w_addr_i,
  input  logic [WW-1:0]         w_data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  y_valid_o,
  output logic [N_OUT*OW-1:0]   y_o,
  output logic [N_OUT-1:0]      sat_o
);

  localparam int NW  = N_IN * N_OUT;
  localparam int IW  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int NNW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int AW  = XW + WW + 1 + $clog2(N_IN);
  localparam int EW  = ((AW > OW) ? AW : OW) + 1;
  localparam logic signed [EW-1:0] Y_MAX = {{(EW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [EW-1:0] Y_MIN = {{(EW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_WB, ST_DONE} state_t;

  state_t                 state_q;
  logic [IW-1:0]          i_q;
  logic [NNW-1:0]         n_q;
  logic signed [AW-1:0]   acc_q;
  logic [N_IN*XW-1:0]     x_q;
  logic                   relu_q;
  logic                   y_valid_q;
  logic [NW*WW-1:0]       w_flat;

  logic [XW-1:0]          x_cur;
  logic [WW-1:0]          w_cur;
  logic signed [AW-1:0]   prod;
  logic signed [EW-1:0]   acc_ext;
  logic [OW-1:0]          y_d;
  logic                   sat_d;

  assign busy_o    = (state_q == ST_MAC) || (state_q == ST_WB);
  assign done_o    = (state_q == ST_DONE) && en_i;
  assign y_valid_o = y_valid_q;

  // Weight registers are writable whenever no run is in flight, regardless of en_i.
  // Out-of-range addresses match no register and are dropped.
  genvar gi;
  generate
    for (gi = 0; gi < NW; gi++) begin : g_w
      logic [WW-1:0] w_q;
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          w_q <= '0;
        end else if (w_we_i && !busy_o && (32'(w_addr_i) == gi)) begin
          w_q <= w_data_i;
        end
      end
      assign w_flat[gi*WW +: WW] = w_q;
    end
  endgenerate

  assign x_cur = x_q[i_q*XW +: XW];
  assign w_cur = w_flat[(n_q*N_IN + i_q)*WW +: WW];
  // Zero-extended sample times signed weight, computed at full accumulator width.
  assign prod    = AW'($signed({1'b0, x_cur})) * AW'($signed(w_cur));
  assign acc_ext = EW'(acc_q);

  always_comb begin
    y_d   = acc_ext[OW-1:0];
    sat_d = 1'b0;
    if (relu_q && acc_q[AW-1]) begin
      y_d = '0;
    end else if (acc_ext > Y_MAX) begin
      y_d   = Y_MAX[OW-1:0];
      sat_d = 1'b1;
    end else if (acc_ext < Y_MIN) begin
      y_d   = Y_MIN[OW-1:0];
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      i_q       <= '0;
      n_q       <= '0;
      acc_q     <= '0;
      x_q       <= '0;
      relu_q    <= 1'b0;
      y_valid_q <= 1'b0;
    end else if (en_i) begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            x_q       <= x_i;
            relu_q    <= relu_en_i;
            acc_q     <= '0;
            i_q       <= '0;
            n_q       <= '0;
            y_valid_q <= 1'b0;
            state_q   <= ST_MAC;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_MAC: begin
          acc_q <= acc_q + prod;
          if (i_q == IW'(N_IN - 1)) begin
            state_q <= ST_WB;
          end else begin
            i_q <= i_q + 1'b1;
          end
        end
        ST_WB: begin
          if (n_q == NNW'(N_OUT - 1)) begin
            state_q   <= ST_DONE;
            y_valid_q <= 1'b1;
          end else begin
            n_q     <= n_q + 1'b1;
            i_q     <= '0;
            acc_q   <= '0;
            state_q <= ST_MAC;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Each neuron's result is only replaced by its own write-back.
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_y
      logic [OW-1:0] y_q;
      logic          sat_q;
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          y_q   <= '0;
          sat_q <= 1'b0;
        end else if (en_i && (state_q == ST_WB) && (32'(n_q) == gi)) begin
          y_q   <= y_d;
          sat_q <= sat_d;
        end
      end
      assign y_o[gi*OW +: OW] = y_q;
      assign sat_o[gi]        = sat_q;
    end
  endgenerate

endmodule
